// File: rtl/dstack_regfile_if.sv
// Command/result bundle between the data-stack control logic (master) and the
// stack register file (slave).
interface dstack_regfile_if #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 32
);
    localparam int DEPTH_W = $clog2(DEPTH + 1);

    logic                  halt;
    logic [1:0]            movement;
    logic [WORD_WIDTH-1:0] next_top;
    logic                  rotate;
    logic [4:0]            rotate_addr;

    logic [WORD_WIDTH-1:0] top;
    logic [WORD_WIDTH-1:0] second;
    logic [WORD_WIDTH-1:0] third;
    logic [WORD_WIDTH-1:0] rotate_value;
    logic [DEPTH_W-1:0]    depth;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output halt, movement, next_top, rotate, rotate_addr,
        input  top, second, third, rotate_value, depth, overflow, underflow
    );

    modport slave (
        input  halt, movement, next_top, rotate, rotate_addr,
        output top, second, third, rotate_value, depth, overflow, underflow
    );
endinterface

// File: rtl/dstack_regfile.sv
// Register-based shift data stack (entry 0 is top), 4 <= DEPTH <= 32.
// Define DSTACK_DEPTH_TRACK_EN to build the depth counter and overflow/underflow flags.
module dstack_regfile #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input logic             clk,
    input logic             reset_n,
    dstack_regfile_if.slave bus
);
    localparam int         DEPTH_W = $clog2(DEPTH + 1);
    localparam logic [5:0] DEPTH_6 = 6'(DEPTH);

    logic [WORD_WIDTH-1:0] entries      [DEPTH];
    logic [WORD_WIDTH-1:0] entries_next [DEPTH];
    // Entries padded with two zero words below the bottom so pops shift in zeros.
    logic [WORD_WIDTH-1:0] padded       [DEPTH+2];
    logic [4:0]            rot_k;
    logic [WORD_WIDTH-1:0] rot_val;

    always_comb begin
        rot_k = ({1'b0, bus.rotate_addr} >= DEPTH_6) ? 5'(DEPTH - 1) : bus.rotate_addr;
    end

    always_comb begin
        rot_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rotate_addr == 5'(i)) rot_val = entries[i];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) padded[i] = entries[i];
        padded[DEPTH]     = '0;
        padded[DEPTH + 1] = '0;
    end

    always_comb begin
        entries_next[0] = bus.next_top;
        for (int i = 1; i < DEPTH; i++) begin
            entries_next[i] = entries[i];
            if (bus.rotate) begin
                if (5'(i) <= rot_k) entries_next[i] = entries[i-1];
            end else begin
                case (bus.movement)
                    2'b01:   entries_next[i] = entries[i-1];
                    2'b10:   entries_next[i] = padded[i+1];
                    2'b11:   entries_next[i] = padded[i+2];
                    default: entries_next[i] = entries[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (!bus.halt) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= entries_next[i];
        end
    end

    assign bus.top          = entries[0];
    assign bus.second       = entries[1];
    assign bus.third        = entries[2];
    assign bus.rotate_value = rot_val;

`ifdef DSTACK_DEPTH_TRACK_EN
    logic [DEPTH_W-1:0] depth_q;
    logic               overflow_q;
    logic               underflow_q;
    logic [5:0]         depth_6;
    logic [5:0]         addr_6;

    assign depth_6 = 6'(depth_q);
    assign addr_6  = {1'b0, bus.rotate_addr};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!bus.halt) begin
            if (bus.rotate) begin
                if (addr_6 >= depth_6) underflow_q <= 1'b1;
            end else begin
                case (bus.movement)
                    2'b00: begin
                        if (depth_q == '0) underflow_q <= 1'b1;
                    end
                    2'b01: begin
                        if (depth_q == DEPTH_W'(DEPTH)) overflow_q <= 1'b1;
                        else                            depth_q    <= depth_q + 1'b1;
                        // A push carrying a nonzero rotate_addr is a copy from that entry.
                        if (bus.rotate_addr != 5'd0 && addr_6 >= depth_6) underflow_q <= 1'b1;
                    end
                    2'b10: begin
                        if (depth_q < DEPTH_W'(2)) underflow_q <= 1'b1;
                        depth_q <= (depth_q == '0) ? '0 : depth_q - 1'b1;
                    end
                    default: begin
                        if (depth_q < DEPTH_W'(3)) underflow_q <= 1'b1;
                        depth_q <= (depth_q < DEPTH_W'(2)) ? '0 : depth_q - DEPTH_W'(2);
                    end
                endcase
            end
        end
    end

    assign bus.depth     = depth_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.depth     = '0;
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_dstack_regfile.sv
// Scoreboard bench for dstack_regfile: a behavioural stack model queues the expected
// post-edge outputs for every driven cycle; each scenario task pops and compares them.
module tb_dstack_regfile;
    localparam int WW    = 32;
    localparam int DEPTH = 32;
    localparam int DW    = $clog2(DEPTH + 1);
`ifdef DSTACK_DEPTH_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    typedef struct packed {
        logic [WW-1:0] top;
        logic [WW-1:0] second;
        logic [WW-1:0] third;
        logic [DW-1:0] depth;
        logic          ovf;
        logic          unf;
    } snap_t;

    logic clk = 1'b0;
    logic reset_n;

    dstack_regfile_if #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) bus ();
    dstack_regfile #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    snap_t         sb[$];
    logic [WW-1:0] m [DEPTH];
    int            m_depth;
    bit            m_ovf;
    bit            m_unf;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic model_step(input logic rn, input logic h, input logic [1:0] mv,
                              input logic [WW-1:0] nt, input logic rot, input logic [4:0] ra);
        logic [WW-1:0] old [DEPTH];
        int k;
        if (!rn) begin
            for (int j = 0; j < DEPTH; j++) m[j] = '0;
            m_depth = 0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            return;
        end
        if (h) return;
        old = m;
        if (rot) begin
            k = (int'(ra) >= DEPTH) ? DEPTH - 1 : int'(ra);
            for (int j = 1; j <= k; j++) m[j] = old[j-1];
            if (int'(ra) >= m_depth) m_unf = 1'b1;
        end else begin
            case (mv)
                2'b00: if (m_depth == 0) m_unf = 1'b1;
                2'b01: begin
                    if (m_depth == DEPTH) m_ovf = 1'b1;
                    if (ra != 5'd0 && int'(ra) >= m_depth) m_unf = 1'b1;
                    for (int j = 1; j < DEPTH; j++) m[j] = old[j-1];
                    if (m_depth < DEPTH) m_depth++;
                end
                2'b10: begin
                    if (m_depth < 2) m_unf = 1'b1;
                    for (int j = 1; j < DEPTH; j++) begin
                        if (j + 1 < DEPTH) m[j] = old[j+1];
                        else               m[j] = '0;
                    end
                    m_depth = (m_depth > 0) ? m_depth - 1 : 0;
                end
                default: begin
                    if (m_depth < 3) m_unf = 1'b1;
                    for (int j = 1; j < DEPTH; j++) begin
                        if (j + 2 < DEPTH) m[j] = old[j+2];
                        else               m[j] = '0;
                    end
                    m_depth = (m_depth > 2) ? m_depth - 2 : 0;
                end
            endcase
        end
        m[0] = nt;
    endtask

    function automatic snap_t mk(input logic [WW-1:0] t, input logic [WW-1:0] s,
                                 input logic [WW-1:0] th, input int d, input bit o, input bit u);
        snap_t r;
        r.top    = t;
        r.second = s;
        r.third  = th;
        r.depth  = TRACK ? DW'(d) : '0;
        r.ovf    = TRACK & o;
        r.unf    = TRACK & u;
        return r;
    endfunction

    function automatic snap_t model_snap();
        return mk(m[0], m[1], m[2], m_depth, m_ovf, m_unf);
    endfunction

    function automatic snap_t observed();
        snap_t r;
        r.top    = bus.top;
        r.second = bus.second;
        r.third  = bus.third;
        r.depth  = bus.depth;
        r.ovf    = bus.overflow;
        r.unf    = bus.underflow;
        return r;
    endfunction

    function automatic logic [WW-1:0] model_rv(input logic [4:0] ra);
        return (int'(ra) < DEPTH) ? m[ra] : '0;
    endfunction

    task automatic drive(input logic rn, input logic h, input logic [1:0] mv,
                         input logic [WW-1:0] nt, input logic rot, input logic [4:0] ra);
        reset_n         = rn;
        bus.halt        = h;
        bus.movement    = mv;
        bus.next_top    = nt;
        bus.rotate      = rot;
        bus.rotate_addr = ra;
        model_step(rn, h, mv, nt, rot, ra);
        sb.push_back(model_snap());
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        snap_t e, o;
        drive(1'b0, 1'b1, 2'b01, 32'hDEAD_BEEF, 1'b1, 5'd3);
        tick();
        e = sb.pop_front(); o = observed(); n_checks++;
        if (o !== e) $display("FAIL reset_state: got %h expected %h", o, e); else n_pass++;
        n_checks++;
        if (o !== mk('0, '0, '0, 0, 0, 0)) $display("FAIL reset_zero: got %h expected 0", o); else n_pass++;
        drive(1'b1, 1'b1, 2'b00, 32'h1234, 1'b0, 5'd5);
        #1;
        n_checks++;
        if (bus.rotate_value !== 32'h0) $display("FAIL reset_rotval: got %h expected 0", bus.rotate_value); else n_pass++;
        tick();
        e = sb.pop_front(); o = observed(); n_checks++;
        if (o !== e) $display("FAIL reset_halt_hold: got %h expected %h", o, e); else n_pass++;
    endtask

    task automatic test_push_pop();
        snap_t e, o;
        logic [WW-1:0] vals [3] = '{32'h11, 32'h22, 32'h33};
        foreach (vals[i]) begin
            drive(1'b1, 1'b0, 2'b01, vals[i], 1'b0, 5'd0);
            tick();
            e = sb.pop_front(); o = observed(); n_checks++;
            if (o !== e) $display("FAIL push_%0d: got %h expected %h", i, o, e); else n_pass++;
        end
        n_checks++;
        if (o !== mk(32'h33, 32'h22, 32'h11, 3, 0, 0)) $display("FAIL push3_const: got %h", o); else n_pass++;
        drive(1'b1, 1'b0, 2'b10, 32'h55, 1'b0, 5'd0);
        tick();
        e = sb.pop_front(); o = observed(); n_checks++;
        if (o !== e || o !== mk(32'h55, 32'h11, 32'h0, 2, 0, 0))
            $display("FAIL pop_one: got %h expected %h", o, e);
        else n_pass++;
        drive(1'b1, 1'b0, 2'b11, 32'h66, 1'b0, 5'd0);
        tick();
        e = sb.pop_front(); o = observed(); n_checks++;
        if (o !== e || o !== mk(32'h66, 32'h0, 32'h0, 0, 0, 1))
            $display("FAIL pop_two: got %h expected %h", o, e);
        else n_pass++;
    endtask

    task automatic test_rotate();
        snap_t e, o;
        logic [WW-1:0] rv;
        drive(1'b0, 1'b0, 2'b00, '0, 1'b0, 5'd0);
        tick(); void'(sb.pop_front());
        for (int v = 1; v <= 5; v++) begin
            drive(1'b1, 1'b0, 2'b01, WW'(v), 1'b0, 5'd0);
            tick();
            e = sb.pop_front(); o = observed(); n_checks++;
            if (o !== e) $display("FAIL rot_fill_%0d: got %h expected %h", v, o, e); else n_pass++;
        end
        drive(1'b1, 1'b1, 2'b00, '0, 1'b0, 5'd3);
        #1;
        rv = bus.rotate_value;
        n_checks++;
        if (rv !== 32'h2) $display("FAIL rot_value_pre: got %h expected 2", rv); else n_pass++;
        tick(); void'(sb.pop_front());
        drive(1'b1, 1'b0, 2'b00, rv, 1'b1, 5'd3);
        tick();
        e = sb.pop_front(); o = observed(); n_checks++;
        if (o !== e || o !== mk(32'h2, 32'h5, 32'h4, 5, 0, 0))
            $display("FAIL rotate3: got %h expected %h", o, e);
        else n_pass++;
        for (int a = 3; a <= 4; a++) begin
            drive(1'b1, 1'b1, 2'b00, '0, 1'b0, 5'(a));
            #1;
            n_checks++;
            if (bus.rotate_value !== ((a == 3) ? 32'h3 : 32'h1))
                $display("FAIL rot_probe_e%0d: got %h expected %h", a, bus.rotate_value, model_rv(5'(a)));
            else n_pass++;
            tick(); void'(sb.pop_front());
        end
    endtask

    task automatic test_halt();
        snap_t e, o;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 2'b01, 32'hA0, 1'b0, 5'd0);
            tick();
            e = sb.pop_front(); o = observed(); n_checks++;
            if (o !== e || o.top !== 32'h2) $display("FAIL halt_hold_%0d: got %h expected %h", c, o, e); else n_pass++;
        end
        drive(1'b1, 1'b0, 2'b01, 32'hA0, 1'b0, 5'd0);
        tick();
        e = sb.pop_front(); o = observed(); n_checks++;
        if (o !== e || o !== mk(32'hA0, 32'h2, 32'h5, 6, 0, 0))
            $display("FAIL halt_release: got %h expected %h", o, e);
        else n_pass++;
    endtask

    task automatic test_overflow();
        snap_t e, o;
        int errs = 0;
        drive(1'b0, 1'b0, 2'b00, '0, 1'b0, 5'd0);
        tick(); void'(sb.pop_front());
        for (int v = 1; v <= DEPTH + 1; v++) begin
            drive(1'b1, 1'b0, 2'b01, WW'(v), 1'b0, 5'd0);
            tick();
            e = sb.pop_front(); o = observed();
            if (o !== e) errs++;
        end
        n_checks++;
        if (errs != 0) $display("FAIL fill_stream: %0d mismatching cycles, expected 0", errs); else n_pass++;
        n_checks++;
        if (o !== mk(33, 32, 31, DEPTH, 1, 0)) $display("FAIL full_const: got %h", o); else n_pass++;
        drive(1'b1, 1'b1, 2'b00, '0, 1'b0, 5'd31);
        #1;
        n_checks++;
        if (bus.rotate_value !== 32'h2) $display("FAIL bottom_e31: got %h expected 2", bus.rotate_value); else n_pass++;
        tick(); void'(sb.pop_front());
        drive(1'b0, 1'b0, 2'b01, 32'hBEEF, 1'b0, 5'd0);
        tick();
        e = sb.pop_front(); o = observed(); n_checks++;
        if (o !== e || o !== mk('0, '0, '0, 0, 0, 0)) $display("FAIL midstream_reset: got %h expected %h", o, e); else n_pass++;
    endtask

    task automatic test_copy();
        snap_t e, o;
        logic [WW-1:0] rv;
        drive(1'b1, 1'b0, 2'b01, 32'h10, 1'b0, 5'd0); tick(); void'(sb.pop_front());
        drive(1'b1, 1'b0, 2'b01, 32'h20, 1'b0, 5'd0); tick(); void'(sb.pop_front());
        drive(1'b1, 1'b1, 2'b00, '0, 1'b0, 5'd7);
        #1;
        rv = bus.rotate_value;
        n_checks++;
        if (rv !== 32'h0) $display("FAIL copy_rotval: got %h expected 0", rv); else n_pass++;
        tick(); void'(sb.pop_front());
        drive(1'b1, 1'b0, 2'b01, rv, 1'b0, 5'd7);
        tick();
        e = sb.pop_front(); o = observed(); n_checks++;
        if (o !== e || o !== mk(32'h0, 32'h20, 32'h10, 3, 0, 1))
            $display("FAIL copy_beyond_depth: got %h expected %h", o, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        snap_t e, o;
        logic [4:0] ra;
        logic [WW-1:0] exp_rv;
        int errs = 0, rv_errs = 0;
        drive(1'b0, 1'b0, 2'b00, '0, 1'b0, 5'd0);
        tick(); void'(sb.pop_front());
        for (int c = 0; c < 400; c++) begin
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            exp_rv = model_rv(ra);
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                  $urandom, ($urandom_range(0, 5) == 0), ra);
            #1;
            if (bus.rotate_value !== exp_rv) rv_errs++;
            tick();
            e = sb.pop_front(); o = observed();
            if (o !== e) begin
                errs++;
                if (errs <= 3) $display("FAIL b2b_cycle_%0d: got %h expected %h", c, o, e);
            end
        end
        n_checks++;
        if (errs != 0) $display("FAIL b2b_state: %0d bad cycles, expected 0", errs); else n_pass++;
        n_checks++;
        if (rv_errs != 0) $display("FAIL b2b_rotval: %0d bad cycles, expected 0", rv_errs); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n         = 1'b0;
        bus.halt        = 1'b0;
        bus.movement    = 2'b00;
        bus.next_top    = '0;
        bus.rotate      = 1'b0;
        bus.rotate_addr = 5'd0;
        for (int j = 0; j < DEPTH; j++) m[j] = '0;
        m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk);
        test_reset();
        test_push_pop();
        test_rotate();
        test_halt();
        test_overflow();
        test_copy();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
